// File: rtl/common.sv
// ============================================================================
// Module      : common (package)
// Description : Small scalar aliases shared across the core codebase.
//               bool - single-bit truth value
//               u32  - 32-bit unsigned quantity
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;

    typedef logic        bool;
    typedef logic [31:0] u32;

endpackage : common

`default_nettype wire

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg (package)
// Description : Shared types for the pipeline controller and its users.
//               stage_idx_t - index of a pipeline stage
//               stage_vec_t - one bit per pipeline stage
//               cnt_t       - performance counter value
//               The types are sized for the default core configuration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    import common::*;

    localparam u32 c_NSTAGE = 32'd5;
    localparam u32 c_CNT_W  = 32'd64;

    typedef logic [$clog2(c_NSTAGE)-1:0] stage_idx_t;
    typedef logic [c_NSTAGE-1:0]         stage_vec_t;
    typedef logic [c_CNT_W-1:0]          cnt_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_ctrl_perf_counter.sv
// ============================================================================
// Module      : perf_counter
// Description : Free-running event counter with synchronous clear.
//               Wraps modulo 2^WIDTH.
// Ports       : clk      - clock
//               rst      - synchronous active-high clear
//               i_inc    - count one event this cycle
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : perf_counter

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Per-stage hold/bubble/squash controller for an in-order
//               pipeline. Tracks a valid bit per stage, drives the load
//               enables of the inter-stage registers, flags retirement and
//               keeps the performance counters.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               fetch_ok      - stage 0 presents a valid instruction
//               stall_req     - per-stage "cannot complete" request
//               flush         - instruction in flush_stage redirects the PC
//               flush_stage   - index of the redirecting stage
//               reg_en        - load enable, register between stage k, k+1
//               stage_valid   - per-stage live-instruction flag
//               commit_valid  - last stage retires this cycle
//               redirect      - flush accepted this cycle
//               *_cnt         - cycle / commit / stall / flush counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import common::*;
    import pipe_pkg::*;
#(
    parameter int NSTAGE = int'(c_NSTAGE),
    parameter int CNT_W  = int'(c_CNT_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_ok,
    input  logic [NSTAGE-1:0]         stall_req,
    input  logic                      flush,
    input  logic [$clog2(NSTAGE)-1:0] flush_stage,
    output logic [NSTAGE-2:0]         reg_en,
    output logic [NSTAGE-1:0]         stage_valid,
    output logic                      commit_valid,
    output logic                      redirect,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [CNT_W-1:0]          commit_cnt,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int c_IDX_W = $clog2(NSTAGE);

    // Registered valid bits for stages 1..NSTAGE-1; stage 0 is fetch_ok.
    logic [NSTAGE-1:1] r_vld;
    logic [NSTAGE-1:1] w_vld_nxt;
    logic [NSTAGE-1:0] w_vld;

    // w_held[NSTAGE] is the always-free sink beyond writeback.
    logic [NSTAGE:0]   w_held;
    logic [NSTAGE-1:1] w_squash;
    logic              w_stage_free;
    bool               w_acc;
    logic              w_commit;

    assign w_vld = {r_vld, fetch_ok};

    // A stall at stage k blocks k and every younger (lower-index) stage.
    always_comb begin
        w_held = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            w_held[k] = stall_req[k] | w_held[k+1];
        end
    end

    // Only stages 1..NSTAGE-1 can redirect; any other index never matches,
    // so out-of-range requests fall through as "not free" and are ignored.
    always_comb begin
        w_stage_free = 1'b0;
        for (int k = 1; k < NSTAGE; k++) begin
            if (flush_stage == c_IDX_W'(k)) begin
                w_stage_free = ~w_held[k];
            end
        end
    end

    assign w_acc = flush & w_stage_free;

    // Squash the redirecting stage and everything younger than it.
    always_comb begin
        w_squash = '0;
        for (int j = 1; j < NSTAGE; j++) begin
            w_squash[j] = w_acc & (c_IDX_W'(j) <= flush_stage);
        end
    end

    // Next valid state: squash beats hold; a held producer feeding a free
    // consumer leaves a bubble behind.
    always_comb begin
        w_vld_nxt = r_vld;
        for (int j = 1; j < NSTAGE; j++) begin
            if (w_squash[j]) begin
                w_vld_nxt[j] = 1'b0;
            end else if (!w_held[j]) begin
                w_vld_nxt[j] = w_vld[j-1] & ~w_held[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld_nxt;
        end
    end

    // Payload registers may load garbage on a squash; the valid bit governs.
    for (genvar k = 0; k < NSTAGE - 1; k++) begin : g_reg_en
        assign reg_en[k] = ~w_held[k+1] | w_squash[k+1];
    end

    // Gated by rst so that neither pulse appears while reset is asserted.
    assign w_commit     = r_vld[NSTAGE-1] & ~stall_req[NSTAGE-1] & ~rst;
    assign commit_valid = w_commit;
    assign redirect     = w_acc & ~rst;
    assign stage_valid  = w_vld;

    perf_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .o_count (cycle_cnt)
    );

    perf_counter #(.WIDTH(CNT_W)) u_commit_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_commit),
        .o_count (commit_cnt)
    );

    perf_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (~w_commit),
        .o_count (stall_cnt)
    );

    perf_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_acc),
        .o_count (flush_cnt)
    );

endmodule : pipe_ctrl

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (NSTAGE=5, CNT_W=64):
//               directed vector table, multi-cycle sequences and a
//               randomized run against an instruction-tracking model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int CW = 64;
    localparam int IW = $clog2(NS);

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_ok;
    logic [NS-1:0] stall_req;
    logic          flush;
    logic [IW-1:0] flush_stage;
    logic [NS-2:0] reg_en;
    logic [NS-1:0] stage_valid;
    logic          commit_valid;
    logic          redirect;
    logic [CW-1:0] cycle_cnt, commit_cnt, stall_cnt, flush_cnt;

    pipe_ctrl #(.NSTAGE(NS), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_ok     (fetch_ok),
        .stall_req    (stall_req),
        .flush        (flush),
        .flush_stage  (flush_stage),
        .reg_en       (reg_en),
        .stage_valid  (stage_valid),
        .commit_valid (commit_valid),
        .redirect     (redirect),
        .cycle_cnt    (cycle_cnt),
        .commit_cnt   (commit_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: tracks instruction ids ----------
    int              slot[NS];   // slot[k] = id in stage k, 0 = empty (k>=1)
    int              next_id;
    longint unsigned m_cyc, m_com, m_stl, m_fl;

    function automatic bit m_held(int k);
        return (stall_req >> k) != 0;
    endfunction

    function automatic bit m_acc();
        int fs = int'(flush_stage);
        return flush && fs >= 1 && fs <= NS - 1 && !m_held(fs);
    endfunction

    function automatic bit m_cv();
        return !rst && slot[NS-1] != 0 && !stall_req[NS-1];
    endfunction

    task automatic model_check();
        logic [NS-1:0] e_sv;
        logic [NS-2:0] e_en;
        bit            acc;
        acc = m_acc();
        e_sv[0] = fetch_ok;
        for (int k = 1; k < NS; k++) e_sv[k] = (slot[k] != 0);
        for (int k = 0; k < NS - 1; k++)
            e_en[k] = !m_held(k + 1) || (acc && (k + 1) <= int'(flush_stage));
        chk("rnd_stage_valid", 64'(stage_valid), 64'(e_sv));
        chk("rnd_reg_en", 64'(reg_en), 64'(e_en));
        chk("rnd_commit_valid", 64'(commit_valid), 64'(m_cv()));
        chk("rnd_redirect", 64'(redirect), 64'(acc && !rst));
        chk("rnd_cycle_cnt", cycle_cnt, m_cyc);
        chk("rnd_commit_cnt", commit_cnt, m_com);
        chk("rnd_stall_cnt", stall_cnt, m_stl);
        chk("rnd_flush_cnt", flush_cnt, m_fl);
    endtask

    task automatic model_step();
        int nxt[NS];
        int src;
        bit acc;
        acc = m_acc();
        if (rst) begin
            for (int k = 0; k < NS; k++) slot[k] = 0;
            m_cyc = 0; m_com = 0; m_stl = 0; m_fl = 0;
        end else begin
            m_cyc++;
            if (m_cv()) m_com++; else m_stl++;
            if (acc) m_fl++;
            src = fetch_ok ? next_id : 0;
            for (int j = 1; j < NS; j++) begin
                if (acc && j <= int'(flush_stage)) nxt[j] = 0;
                else if (m_held(j))                nxt[j] = slot[j];
                else if (m_held(j - 1))            nxt[j] = 0;
                else                               nxt[j] = (j == 1) ? src : slot[j-1];
            end
            for (int j = 1; j < NS; j++) slot[j] = nxt[j];
            if (fetch_ok && !m_held(0)) next_id++;
        end
    endtask

    // ---------------- directed vector table ------------------------------
    typedef struct {
        logic          rst;
        logic          fo;
        logic [NS-1:0] st;
        logic          fl;
        logic [IW-1:0] fs;
        logic [NS-2:0] en;
        logic [NS-1:0] sv;
        logic          cv;
        logic          rd;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic r, input logic fo, input logic [NS-1:0] st,
                         input logic fl, input logic [IW-1:0] fs);
        rst = r; fetch_ok = fo; stall_req = st; flush = fl; flush_stage = fs;
    endtask

    initial begin
        logic [CW-1:0] c_stl0, c_com0;
        logic          cv_pat[7];

        //          rst fo  stall     fl  fs    reg_en   stage_valid cv  rd
        tbl.push_back('{1, 0, 5'b00000, 0, 3'd0, 4'b1111, 5'b00000, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b00001, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b00011, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b00111, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b01111, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b11111, 1, 0});
        tbl.push_back('{0, 1, 5'b01000, 0, 3'd0, 4'b1000, 5'b11111, 1, 0});
        tbl.push_back('{0, 1, 5'b01000, 0, 3'd0, 4'b1000, 5'b01111, 0, 0});
        tbl.push_back('{0, 1, 5'b01000, 0, 3'd0, 4'b1000, 5'b01111, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b01111, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 1, 3'd2, 4'b1111, 5'b11111, 1, 1});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b11001, 1, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b10011, 1, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b00111, 0, 0});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b01111, 0, 0});
        tbl.push_back('{0, 1, 5'b01000, 1, 3'd2, 4'b1000, 5'b11111, 1, 0});
        tbl.push_back('{0, 1, 5'b00000, 1, 3'd2, 4'b1111, 5'b01111, 0, 1});
        tbl.push_back('{0, 1, 5'b00000, 1, 3'd0, 4'b1111, 5'b11001, 1, 0});
        tbl.push_back('{0, 1, 5'b00000, 1, 3'd7, 4'b1111, 5'b10011, 1, 0});
        tbl.push_back('{0, 1, 5'b00010, 1, 3'd3, 4'b1111, 5'b00111, 0, 1});
        tbl.push_back('{0, 1, 5'b00000, 0, 3'd0, 4'b1111, 5'b00001, 0, 0});
        tbl.push_back('{1, 1, 5'b00000, 1, 3'd2, 4'b1111, 5'b00011, 0, 0});
        tbl.push_back('{0, 0, 5'b00000, 0, 3'd0, 4'b1111, 5'b00000, 0, 0});

        drive(1, 0, '0, 0, '0);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].fo, tbl[i].st, tbl[i].fl, tbl[i].fs);
            #1;
            chk($sformatf("tbl%0d_reg_en", i), 64'(reg_en), 64'(tbl[i].en));
            chk($sformatf("tbl%0d_stage_valid", i), 64'(stage_valid), 64'(tbl[i].sv));
            chk($sformatf("tbl%0d_commit_valid", i), 64'(commit_valid), 64'(tbl[i].cv));
            chk($sformatf("tbl%0d_redirect", i), 64'(redirect), 64'(tbl[i].rd));
        end

        // Fill from reset: 14 edges of continuous fetch.
        @(negedge clk); drive(1, 0, '0, 0, '0);
        @(negedge clk); drive(0, 1, '0, 0, '0);
        repeat (14) @(posedge clk);
        @(negedge clk); #1;
        chk("fill_cycle_cnt", cycle_cnt, 64'd14);
        chk("fill_commit_cnt", commit_cnt, 64'd10);
        chk("fill_stall_cnt", stall_cnt, 64'd4);
        chk("fill_flush_cnt", flush_cnt, 64'd0);

        // Fetch stall for 2 cycles: 2 bubbles reach commit 4 cycles later.
        cv_pat = '{1, 1, 1, 1, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            stall_req = (i < 2) ? 5'b00001 : 5'b00000;
            #1;
            chk($sformatf("s0stall%0d_commit_valid", i), 64'(commit_valid), 64'(cv_pat[i]));
            chk($sformatf("s0stall%0d_reg_en", i), 64'(reg_en), 64'hF);
        end

        // Stage-3 stall for 3 cycles: stall_cnt +3, commit_cnt +1.
        @(negedge clk); #1;
        c_stl0 = stall_cnt;
        c_com0 = commit_cnt;
        for (int i = 0; i < 4; i++) begin
            stall_req = (i < 3) ? 5'b01000 : 5'b00000;
            @(negedge clk); #1;
        end
        chk("s3stall_stall_delta", stall_cnt - c_stl0, 64'd3);
        chk("s3stall_commit_delta", commit_cnt - c_com0, 64'd1);

        // Reset in the middle of a stalled flush clears everything.
        drive(1, 1, 5'b01000, 1, 3'd2);
        @(negedge clk);
        drive(0, 0, '0, 0, '0);
        #1;
        chk("midrst_stage_valid", 64'(stage_valid[NS-1:1]), 64'd0);
        chk("midrst_cycle_cnt", cycle_cnt, 64'd0);
        chk("midrst_commit_cnt", commit_cnt, 64'd0);
        chk("midrst_stall_cnt", stall_cnt, 64'd0);
        chk("midrst_flush_cnt", flush_cnt, 64'd0);
        chk("midrst_commit_valid", 64'(commit_valid), 64'd0);

        // Randomized run against the model; iteration 0 resets both.
        next_id = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst         = (i == 0) || ($urandom_range(0, 63) == 0);
            fetch_ok    = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < NS; k++) stall_req[k] = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 5) == 0);
            flush_stage = IW'($urandom_range(0, (1 << IW) - 1));
            #1;
            if (i > 0) model_check();
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pipe_ctrl

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline controller for the N-stage in-order core. Each stage gets its own hold, bubble and squash control, so a fetch wait inserts bubbles instead of freezing the whole pipe. The block tracks per-stage valid bits, so retirement comes from real valid state rather than a post-reset cycle count. It also owns the performance counters. It sits beside the pipeline registers in the core top, drives their load enables and feeds `commit_valid` to DiffTest.

## Interface
- `NSTAGE`, 5: number of stages, ≥2. Stage 0 is fetch; stage NSTAGE-1 is writeback.
- `CNT_W`, 64: width of each performance counter.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `fetch_ok` in 1: stage 0 is presenting a valid instruction this cycle.
- `stall_req` in NSTAGE: bit k means stage k cannot complete this cycle.
- `flush` in 1: the instruction in `flush_stage` redirects the PC.
- `flush_stage` in $clog2(NSTAGE): index of the redirecting stage.
- `reg_en` out NSTAGE-1: bit k loads the register between stage k and stage k+1.
- `stage_valid` out NSTAGE: bit k means stage k holds a live instruction. Bit 0 equals `fetch_ok`.
- `commit_valid` out 1: the instruction in stage NSTAGE-1 retires this cycle.
- `redirect` out 1: a flush was accepted this cycle (one-cycle pulse).
- `cycle_cnt`, `commit_cnt`, `stall_cnt`, `flush_cnt` out CNT_W each: performance counters.

## Operation
- Per-stage valid bits `vld[1..NSTAGE-1]` are registered. `vld[0] = fetch_ok`.
- `held[NSTAGE] = 0`. For k from NSTAGE-1 down to 0: `held[k] = stall_req[k] | held[k+1]`, so a stall back-pressures younger stages only.
- Flush acceptance:
  - `acc = flush & (1 ≤ flush_stage ≤ NSTAGE-1) & !held[flush_stage]`.
  - Out-of-range `flush_stage` is ignored.
  - A flush presented while its stage is held is not accepted. The requester keeps `flush` asserted.
- `squash[j] = acc & (j ≤ flush_stage)`, for register inputs j in 1..NSTAGE-1.
- Register into stage j = k+1, evaluated each edge, in priority order:
  - `rst` → `vld[j] <= 0`.
  - `squash[j]` → `vld[j] <= 0`. Squash beats hold.
  - `held[j]` → `vld[j]` keeps its value.
  - Otherwise → `vld[j] <= vld[k] & !held[k]`. A held producer with a free consumer yields a bubble.
- `reg_en[k] = !held[k+1] | squash[k+1]`. The payload may load garbage on a squash; `vld` governs.
- `commit_valid = vld[NSTAGE-1] & !stall_req[NSTAGE-1]`.
- `redirect = acc`.
- Counters, each edge while not in reset (wrap modulo 2^CNT_W, no saturation):
  - `cycle_cnt` +1 every cycle.
  - `commit_cnt` +1 when `commit_valid`.
  - `stall_cnt` +1 when `commit_valid` is 0.
  - `flush_cnt` +1 when `acc`.

## Timing
- `held`, `reg_en`, `commit_valid` and `redirect` are combinational from the same-cycle inputs and `vld`. No input-to-register latency beyond one edge.
- `stage_valid[k≥1]` changes only at `posedge clk`. Counter updates are visible the cycle after the event.
- Reset values while `rst` is high and after the edge:
  - all `vld` = 0, all counters = 0.
  - `commit_valid` = 0, `redirect` = 0.
  - `reg_en` follows `stall_req`, which is harmless.
- Reset asserted mid-operation clears all state at the next edge, regardless of stall or flush.
- Fill latency: an instruction accepted at stage 0 reaches `commit_valid` after NSTAGE-1 edges with no stalls.
- Flush and stall in the same cycle:
  - Stall at a stage ≥ `flush_stage` → no acceptance.
  - Stall at a stage < `flush_stage` → flush accepted, squash wins.

## Structure
- Shared package `pipe_pkg`:
  - `stage_idx_t`, typed `logic [$clog2(NSTAGE)-1:0]`.
  - `stage_vec_t`.
  - counter type `cnt_t`.
- Reuse `bool` and `u32` from `common`.
- Sub-module `perf_counter` (synchronous reset, increment enable, parametrised width), instantiated four times.

## Test plan
- NSTAGE=5, reset released, `fetch_ok`=1, no stalls → `commit_valid` rises after exactly 4 edges and stays 1. `commit_cnt`=10 and `cycle_cnt`=14 after 14 edges.
- Full pipe, `stall_req[3]`=1 for 3 cycles:
  - `reg_en[0..2]`=0, `reg_en[3]`=1.
  - The stage-4 instruction commits in the first stall cycle, then `commit_valid`=0 for 3 cycles.
  - `stall_cnt` increases by 3; no instruction is lost or duplicated.
- Full pipe, `stall_req[0]`=1 for 2 cycles → stages 1–4 keep advancing. Exactly 2 bubbles appear, and `commit_valid`=0 for 2 cycles starting 4 cycles later.
- Full pipe, `flush`=1, `flush_stage`=2, no stalls:
  - `redirect`=1 for that cycle only.
  - Next edge: `vld[1..2]`=0, `vld[3]`=1.
  - `flush_cnt`=1; two bubbles reach commit.
- `flush`=1, `flush_stage`=2 with `stall_req[3]`=1 → `redirect`=0 and `vld` unchanged. When the stall drops with `flush` still 1, the flush is accepted that cycle.
- `rst` asserted for one cycle with a full pipe and nonzero counters → after the edge, all `stage_valid[1..4]`=0, all counters=0 and `commit_valid`=0.
